// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared default constants for the servo PWM timer.
// 100 MHz clock, 10 ms refresh, 1.0 / 1.5 / 2.0 ms pulse limits.
package servo_pwm_pkg;

    localparam int CLK_HZ            = 100_000_000;
    localparam int DEF_PERIOD_CYCLES = CLK_HZ / 100;
    localparam int DEF_CNT_W         = 20;
    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_CH_W          = 2;
    localparam int DEF_MIN_PULSE     = CLK_HZ / 1000;
    localparam int DEF_MAX_PULSE     = CLK_HZ / 500;
    localparam int DEF_RESET_PULSE   = (CLK_HZ / 1000) * 3 / 2;

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one shadow/active width pair plus registered comparator.
// Optional clamp of written widths via SERVO_PWM_CLAMP_EN.
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
`ifdef SERVO_PWM_CLAMP_EN
    parameter int MIN_PULSE   = DEF_MIN_PULSE,
    parameter int MAX_PULSE   = DEF_MAX_PULSE,
`endif
    parameter int RESET_PULSE = DEF_RESET_PULSE
) (
    input  logic             i_Clk,
    input  logic             clr,
    input  logic             en,
    input  logic             wrap,
    input  logic             wr_stb,
    input  logic [CNT_W-1:0] wr_width,
    input  logic [CNT_W-1:0] count,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] RST_W = CNT_W'(RESET_PULSE);
`ifdef SERVO_PWM_CLAMP_EN
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_PULSE);
`endif

    logic [CNT_W-1:0] wr_val;
    logic [CNT_W-1:0] shadow_d, shadow_q;
    logic [CNT_W-1:0] active_d, active_q;
    logic             pwm_d, pwm_q;

    // Next-state: limit the written width, latch shadow, promote on wrap.
    always_comb begin
`ifdef SERVO_PWM_CLAMP_EN
        wr_val = wr_width;
        if (wr_width < MIN_W) begin
            wr_val = MIN_W;
        end else if (wr_width > MAX_W) begin
            wr_val = MAX_W;
        end
`else
        wr_val = wr_width;
`endif
        shadow_d = wr_stb ? wr_val : shadow_q;
        active_d = wrap ? shadow_q : active_q;
        pwm_d    = en && (count < active_q);
    end

    // Width registers and output flop, cleared to the neutral width.
    always_ff @(posedge i_Clk) begin
        if (clr) begin
            shadow_q <= RST_W;
            active_q <= RST_W;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_timer.sv
// servo_pwm_timer: shared period counter driving NUM_CH servo PWM channels.
// Define SERVO_PWM_CLAMP_EN to clamp widths to [MIN_PULSE, MAX_PULSE].
module servo_pwm_timer
    import servo_pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int CH_W          = DEF_CH_W,
    parameter int MIN_PULSE     = DEF_MIN_PULSE,
    parameter int MAX_PULSE     = DEF_MAX_PULSE,
    parameter int RESET_PULSE   = DEF_RESET_PULSE
) (
    input  logic              i_Clk,
    input  logic              clr,
    input  logic              en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_width,
    output logic [CNT_W-1:0]  count,
    output logic              period_tick,
    output logic [NUM_CH-1:0] pwm
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

    if (MIN_PULSE > MAX_PULSE ||
        (64'(1) << CNT_W) <= 64'(PERIOD_CYCLES)) begin : g_bad_cfg
        $error("servo_pwm_timer: inconsistent parameters");
    end

    logic [CNT_W-1:0]  count_d, count_q;
    logic              tick_d, tick_q;
    logic              wrap;
    logic [NUM_CH-1:0] wr_stb;

    // Counter advance, wrap detect and per-channel write decode.
    always_comb begin
        wrap    = en && (count_q == LAST);
        tick_d  = wrap;
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        wr_stb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_stb[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    // Period counter and period-start tick.
    always_ff @(posedge i_Clk) begin
        if (clr) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_channel #(
            .CNT_W       (CNT_W),
`ifdef SERVO_PWM_CLAMP_EN
            .MIN_PULSE   (MIN_PULSE),
            .MAX_PULSE   (MAX_PULSE),
`endif
            .RESET_PULSE (RESET_PULSE)
        ) u_ch (
            .i_Clk    (i_Clk),
            .clr      (clr),
            .en       (en),
            .wrap     (wrap),
            .wr_stb   (wr_stb[i]),
            .wr_width (wr_width),
            .count    (count_q),
            .pwm      (pwm[i])
        );
    end

    assign count       = count_q;
    assign period_tick = tick_q;

endmodule
